// File: rtl/shift_sequencer.sv
// Parallel-to-serial transmit controller for an external logical shift register.
// Loads a captured word, issues WIDTH shift pulses, and qualifies the register's shift_out.
module shift_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             dir_left,
  input  logic             fill_bit,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sr_shift_out,
  output logic             sr_clear,
  output logic             sr_load,
  output logic             sr_shift_left,
  output logic             sr_shift_right,
  output logic             sr_shift_in,
  output logic [WIDTH-1:0] sr_d,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE also accepts start so consecutive words run with no idle gap
        if (start) begin
          word_d  = data_in;
          dir_d   = dir_left;
          fill_d  = fill_bit;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic active;
  logic killed;

  always_comb begin
    active         = (state_q == LOAD) || (state_q == SHIFT);
    killed         = active && abort;
    sr_clear       = killed;
    sr_load        = (state_q == LOAD) && !abort;
    sr_shift_left  = (state_q == SHIFT) && !abort && dir_q;
    sr_shift_right = (state_q == SHIFT) && !abort && !dir_q;
    sr_shift_in    = fill_q;
    sr_d           = word_q;
    serial_valid   = (state_q == SHIFT) && !abort;
    serial_out     = serial_valid & sr_shift_out;
    busy           = active;
    done           = (state_q == DONE);
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift register attached
// and a queue of expected serial bits consumed whenever serial_valid is seen.
module tb_shift_sequencer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset, start, dir_left, fill_bit, abort;
  logic [W-1:0] data_in;
  logic         sr_shift_out;
  logic         sr_clear, sr_load, sr_shift_left, sr_shift_right, sr_shift_in;
  logic [W-1:0] sr_d;
  logic         serial_out, serial_valid, busy, done;

  int tests_run = 0;
  int fails     = 0;
  bit mon_en    = 1'b0;
  logic exp_q[$];

  // {busy, done, load, clear, left, right, valid}
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_LOAD  = 7'b1010000;
  localparam logic [6:0] V_SHL   = 7'b1000101;
  localparam logic [6:0] V_SHR   = 7'b1000011;
  localparam logic [6:0] V_DONE  = 7'b0100000;
  localparam logic [6:0] V_ABORT = 7'b1001000;

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .dir_left       (dir_left),
    .fill_bit       (fill_bit),
    .abort          (abort),
    .data_in        (data_in),
    .sr_shift_out   (sr_shift_out),
    .sr_clear       (sr_clear),
    .sr_load        (sr_load),
    .sr_shift_left  (sr_shift_left),
    .sr_shift_right (sr_shift_right),
    .sr_shift_in    (sr_shift_in),
    .sr_d           (sr_d),
    .serial_out     (serial_out),
    .serial_valid   (serial_valid),
    .busy           (busy),
    .done           (done)
  );

  // Behavioural model of the attached logical shift register
  logic [W-1:0] sr_q;
  always_ff @(posedge clock) begin
    if (!reset)              sr_q <= '0;
    else if (sr_clear)       sr_q <= '0;
    else if (sr_load)        sr_q <= sr_d;
    else if (sr_shift_left)  sr_q <= {sr_q[W-2:0], sr_shift_in};
    else if (sr_shift_right) sr_q <= {sr_shift_in, sr_q[W-1:1]};
  end
  assign sr_shift_out = sr_shift_left ? sr_q[W-1] : (sr_shift_right ? sr_q[0] : 1'b0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {busy, done, sr_load, sr_clear, sr_shift_left, sr_shift_right, serial_valid};
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      if (serial_valid) begin
        if (exp_q.size() == 0) begin
          chk("serial_unexpected", 32'(serial_out), 32'h0000_0BAD);
        end else begin
          chk("serial_bit", 32'(serial_out), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("serial_idle_zero", 32'(serial_out), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic [6:0] exp);
    @(negedge clock);
    chk(tag, 32'(strobes()), 32'(exp));
    tick();
  endtask

  // Drives start across one edge and queues the bits the transfer must emit
  task automatic launch(input logic [W-1:0] data, input logic dl, input logic fb,
                        input logic hold, input logic ab);
    data_in  = data;
    dir_left = dl;
    fill_bit = fb;
    abort    = ab;
    start    = 1'b1;
    for (int i = 0; i < W; i++) exp_q.push_back(dl ? data[W-1-i] : data[i]);
    tick();
    abort = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic walk(input logic dl);
    check_cycle("load", V_LOAD);
    for (int i = 0; i < W; i++) check_cycle("shift", dl ? V_SHL : V_SHR);
    check_cycle("done", V_DONE);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dir_left = 1'b0;
    fill_bit = 1'b0;
    abort    = 1'b0;
    data_in  = '0;
    tick();
    tick();

    // Reset state, with start asserted to show reset dominates
    start = 1'b1;
    @(negedge clock);
    chk("reset_strobes", 32'(strobes()), 32'(V_IDLE));
    chk("reset_sr_d", 32'(sr_d), 32'h0);
    chk("reset_shift_in", 32'(sr_shift_in), 32'h0);
    chk("reset_serial_out", 32'(serial_out), 32'h0);
    tick();
    start  = 1'b0;
    reset  = 1'b1;
    mon_en = 1'b1;
    check_cycle("idle_after_reset", V_IDLE);

    // MSB first, fill 0
    launch(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    walk(1'b1);
    check_cycle("idle_after_t1", V_IDLE);
    chk("t1_reg_end", 32'(sr_q), 32'h0);

    // LSB first, fill 1
    launch(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("t2_sr_d", 32'(sr_d), 32'hB);
    chk("t2_shift_in", 32'(sr_shift_in), 32'h1);
    walk(1'b0);
    check_cycle("idle_after_t2", V_IDLE);
    chk("t2_reg_end", 32'(sr_q), 32'hF);

    // Abort on the second SHIFT cycle
    launch(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cycle("t3_load", V_LOAD);
    check_cycle("t3_shift1", V_SHL);
    abort = 1'b1;
    check_cycle("t3_abort", V_ABORT);
    abort = 1'b0;
    chk("t3_bits_left", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    check_cycle("t3_idle", V_IDLE);
    check_cycle("t3_no_done", V_IDLE);
    chk("t3_reg_cleared", 32'(sr_q), 32'h0);

    // start held through a transfer while data_in changes
    launch(4'b1011, 1'b1, 1'b0, 1'b1, 1'b0);
    data_in  = 4'b0110;
    dir_left = 1'b0;
    fill_bit = 1'b1;
    #1;
    chk("t4_first_word", 32'(sr_d), 32'hB);
    chk("t4_first_fill", 32'(sr_shift_in), 32'h0);
    walk(1'b1);
    // DONE sampled start, so the second LOAD is already underway
    for (int i = 0; i < W; i++) exp_q.push_back(data_in[i]);
    start = 1'b0;
    chk("t4_second_word", 32'(sr_d), 32'h6);
    walk(1'b0);
    check_cycle("idle_after_t4", V_IDLE);
    chk("t4_reg_end", 32'(sr_q), 32'hF);

    // Reset during SHIFT, with start also asserted
    launch(4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);
    check_cycle("t5_load", V_LOAD);
    check_cycle("t5_shift1", V_SHL);
    check_cycle("t5_shift2", V_SHL);
    reset = 1'b0;
    start = 1'b1;
    check_cycle("t5_shift3", V_SHL);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    chk("t5_reset_strobes", 32'(strobes()), 32'(V_IDLE));
    chk("t5_reset_sr_d", 32'(sr_d), 32'h0);
    chk("t5_reset_shift_in", 32'(sr_shift_in), 32'h0);
    chk("t5_bits_left", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tick();
    launch(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    walk(1'b0);
    check_cycle("idle_after_t5", V_IDLE);
    chk("t5_reg_end", 32'(sr_q), 32'h0);

    // start and abort together in IDLE: abort ignored
    launch(4'b1001, 1'b1, 1'b1, 1'b0, 1'b1);
    walk(1'b1);
    check_cycle("idle_after_t6", V_IDLE);
    chk("t6_reg_end", 32'(sr_q), 32'hF);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
